// File: rtl/apb_bridge_pkg.sv
// Shared types for the multi-target host-to-APB bridge: FSM states, the
// posted-write entry layout and small elaboration/decode helpers.
package apb_bridge_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int TARGET_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state_t;

  // Entries are stored at the widest supported width; narrower builds zero-extend.
  typedef struct packed {
    logic [TARGET_W-1:0]  target;
    logic [MAX_WIDTH-1:0] addr;
    logic [MAX_WIDTH-1:0] data;
  } wbuf_entry_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result++;
    end
    return result;
  endfunction

  function automatic logic region_match(
    input logic [MAX_WIDTH-1:0] addr,
    input logic [MAX_WIDTH-1:0] mask,
    input logic [MAX_WIDTH-1:0] value
  );
    return (addr & mask) == value;
  endfunction

endpackage

// File: rtl/apb_multi_host_bridge_if.sv
// APB requester bus between the bridge (master) and the externally muxed
// target side (slave).
interface apb_multi_host_bridge_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_TARGETS = 2
);
  logic [NUM_TARGETS-1:0] apbSel;
  logic                   apbEnable;
  logic                   apbWrite;
  logic [ADDR_WIDTH-1:0]  apbAddr;
  logic [DATA_WIDTH-1:0]  apbWData;
  logic                   apbReady;
  logic [DATA_WIDTH-1:0]  apbRData;
  logic                   apbSlvErr;

  modport master (
    output apbSel, apbEnable, apbWrite, apbAddr, apbWData,
    input  apbReady, apbRData, apbSlvErr
  );

  modport slave (
    input  apbSel, apbEnable, apbWrite, apbAddr, apbWData,
    output apbReady, apbRData, apbSlvErr
  );
endinterface

// File: rtl/strobe_sync.sv
// Multi-stage synchroniser for an asynchronous host strobe, with the
// synchronised level and single-cycle rise/fall pulses.
module strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;
endmodule

// File: rtl/apb_multi_host_bridge.sv
// Asynchronous host bus to APB requester with decoded selects and posted writes.
// Optional build macro APB_TIMEOUT_EN adds a forced termination of stuck ACCESS phases.
module apb_multi_host_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_TARGETS    = 2,
  parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] REGION_MASK  = '0,
  parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] REGION_VALUE = '0,
  parameter int WBUF_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  nHostCS,
  input  logic                  nHostRead,
  input  logic                  nHostWrite,
  input  logic [ADDR_WIDTH-1:0] hostAddr,
  inout  wire  [DATA_WIDTH-1:0] hostData,
  apb_multi_host_bridge_if.master apb,
  input  logic                  errClear,
  output logic                  errOverflow,
  output logic                  errBus
);
  localparam int PTR_W = clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Address decode: lowest matching region wins.
  logic [NUM_TARGETS-1:0] hit_vec;
  logic [TARGET_W-1:0]    hit_target;
  logic                   hit_any;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_decode
      assign hit_vec[gi] = region_match(MAX_WIDTH'(hostAddr),
                                        MAX_WIDTH'(REGION_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                                        MAX_WIDTH'(REGION_VALUE[gi*ADDR_WIDTH +: ADDR_WIDTH]));
    end
  endgenerate

  always_comb begin
    hit_target = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_target = TARGET_W'(i);
    end
  end
  assign hit_any = |hit_vec;

  logic read_raw, write_raw;
  logic rd_level, rd_rise, rd_fall;
  logic wr_level, wr_rise, wr_fall;

  assign read_raw  = ~nHostCS & ~nHostRead & nHostWrite;
  assign write_raw = ~nHostCS & nHostRead & ~nHostWrite;

  strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk), .rst_n(nReset), .din(read_raw),
    .level(rd_level), .rise(rd_rise), .fall(rd_fall)
  );

  strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk), .rst_n(nReset), .din(write_raw),
    .level(wr_level), .rise(wr_rise), .fall(wr_fall)
  );

  logic [TARGET_W-1:0]   wr_target_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;
  logic                  wr_hit_reg;
  logic                  wr_seen_reg;

  // Host may change address/data any time the strobe is up, so keep the latest.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_target_reg <= '0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      wr_hit_reg    <= 1'b0;
      wr_seen_reg   <= 1'b0;
    end else begin
      if (wr_level) begin
        wr_target_reg <= hit_target;
        wr_addr_reg   <= hostAddr;
        wr_data_reg   <= hostData;
        wr_hit_reg    <= hit_any;
      end
      if (wr_rise)      wr_seen_reg <= 1'b1;
      else if (wr_fall) wr_seen_reg <= 1'b0;
    end
  end

  wbuf_entry_t          wbuf_mem [WBUF_DEPTH];
  logic [PTR_W-1:0]     wptr_reg, rptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 fifo_empty, fifo_full;
  logic                 push_req, push, pop, overflow_set;

  apb_state_t            state_reg, state_next;
  logic                  load_write, load_read, done, timeout;
  logic [TARGET_W-1:0]   apb_target_reg;
  logic [ADDR_WIDTH-1:0] apb_addr_reg;
  logic [DATA_WIDTH-1:0] apb_wdata_reg;
  logic                  apb_write_reg;

  assign fifo_empty   = (count_reg == '0);
  assign fifo_full    = (count_reg == CNT_W'(WBUF_DEPTH));
  assign pop          = done & apb_write_reg;
  assign push_req     = wr_fall & wr_seen_reg & wr_hit_reg;
  assign push         = push_req & (~fifo_full | pop);
  assign overflow_set = push_req & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (push) begin
      wbuf_mem[wptr_reg] <= '{target: wr_target_reg,
                              addr:   MAX_WIDTH'(wr_addr_reg),
                              data:   MAX_WIDTH'(wr_data_reg)};
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) wptr_reg <= wptr_reg + PTR_W'(1);
      if (pop)  rptr_reg <= rptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt_reg;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)                   to_cnt_reg <= '0;
    else if (state_reg == ST_ACCESS) to_cnt_reg <= to_cnt_reg + TO_W'(1);
    else                           to_cnt_reg <= '0;
  end

  assign timeout = (state_reg == ST_ACCESS) && !apb.apbReady &&
                   (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  logic                  rd_pending_reg, rd_keep_reg, read_busy;
  logic [TARGET_W-1:0]   rd_target_reg;
  logic [ADDR_WIDTH-1:0] rd_addr_reg;

  // Posted writes drain before a pending read is issued.
  always_comb begin
    state_next = state_reg;
    load_write = 1'b0;
    load_read  = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load_write = 1'b1;
          state_next = ST_SETUP;
        end else if (rd_pending_reg) begin
          load_read  = 1'b1;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (apb.apbReady || timeout) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      apb_target_reg <= '0;
      apb_addr_reg   <= '0;
      apb_wdata_reg  <= '0;
      apb_write_reg  <= 1'b0;
    end else if (load_write) begin
      apb_target_reg <= wbuf_mem[rptr_reg].target;
      apb_addr_reg   <= wbuf_mem[rptr_reg].addr[ADDR_WIDTH-1:0];
      apb_wdata_reg  <= wbuf_mem[rptr_reg].data[DATA_WIDTH-1:0];
      apb_write_reg  <= 1'b1;
    end else if (load_read) begin
      apb_target_reg <= rd_target_reg;
      apb_addr_reg   <= rd_addr_reg;
      apb_write_reg  <= 1'b0;
    end
  end

  assign read_busy = (state_reg != ST_IDLE) && !apb_write_reg;

  // rd_keep_reg drops once the host lets go, so late data is discarded.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rd_pending_reg <= 1'b0;
      rd_keep_reg    <= 1'b0;
      rd_target_reg  <= '0;
      rd_addr_reg    <= '0;
    end else begin
      if (rd_fall) rd_keep_reg <= 1'b0;
      if (rd_rise && hit_any && !rd_pending_reg && !read_busy) begin
        rd_pending_reg <= 1'b1;
        rd_keep_reg    <= 1'b1;
        rd_target_reg  <= hit_target;
        rd_addr_reg    <= hostAddr;
      end else if (load_read) begin
        rd_pending_reg <= 1'b0;
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  drive_reg;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rd_data_reg <= '0;
      drive_reg   <= 1'b0;
    end else if (done && !apb_write_reg) begin
      rd_data_reg <= timeout ? '1 : apb.apbRData;
      drive_reg   <= rd_keep_reg & rd_level;
    end else begin
      drive_reg   <= drive_reg & rd_level;
    end
  end

  assign hostData = drive_reg ? rd_data_reg : {DATA_WIDTH{1'bz}};

  logic err_overflow_reg, err_bus_reg, bus_err_set;
  assign bus_err_set = done & ((apb.apbReady & apb.apbSlvErr) | timeout);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      err_overflow_reg <= 1'b0;
      err_bus_reg      <= 1'b0;
    end else begin
      if (overflow_set)  err_overflow_reg <= 1'b1;
      else if (errClear) err_overflow_reg <= 1'b0;
      if (bus_err_set)   err_bus_reg <= 1'b1;
      else if (errClear) err_bus_reg <= 1'b0;
    end
  end

  assign errOverflow   = err_overflow_reg;
  assign errBus        = err_bus_reg;
  assign apb.apbSel    = (state_reg != ST_IDLE) ? (NUM_TARGETS'(1) << apb_target_reg) : '0;
  assign apb.apbEnable = (state_reg == ST_ACCESS);
  assign apb.apbWrite  = apb_write_reg;
  assign apb.apbAddr   = apb_addr_reg;
  assign apb.apbWData  = apb_wdata_reg;
endmodule

// File: tb/tb_apb_multi_host_bridge.sv
// Directed bench for apb_multi_host_bridge: host bus stimulus, a parametrisable
// APB target model and a transfer log checked against hand-computed values.
module tb_apb_multi_host_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NT = 2;
  // Region 0: 0x0001_xxxx, region 1: 0x0000_xxxx; 0x0002_xxxx matches nothing.
  localparam logic [NT*AW-1:0] R_MASK  = {32'hFFFF_0000, 32'hFFFF_0000};
  localparam logic [NT*AW-1:0] R_VALUE = {32'h0000_0000, 32'h0001_0000};

  logic          clk = 1'b0;
  logic          nReset;
  logic          nHostCS, nHostRead, nHostWrite;
  logic [AW-1:0] hostAddr;
  tri0  [DW-1:0] hostData;
  logic [DW-1:0] host_drv;
  logic          host_oe;
  logic          errClear, errOverflow, errBus;

  apb_multi_host_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TARGETS(NT)) apb_bus ();

  apb_multi_host_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TARGETS(NT),
    .REGION_MASK(R_MASK), .REGION_VALUE(R_VALUE),
    .WBUF_DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .nReset(nReset),
    .nHostCS(nHostCS), .nHostRead(nHostRead), .nHostWrite(nHostWrite),
    .hostAddr(hostAddr), .hostData(hostData),
    .apb(apb_bus),
    .errClear(errClear), .errOverflow(errOverflow), .errBus(errBus)
  );

  always #5 clk = ~clk;

  assign hostData = host_oe ? host_drv : {DW{1'bz}};

  // Target model: ready after wait_states ACCESS cycles when enabled.
  logic          ready_en;
  int            wait_states;
  int            acc_cnt = 0;
  logic [DW-1:0] rdata_val;
  logic          slverr_val;

  assign apb_bus.apbReady  = ready_en && (acc_cnt >= wait_states);
  assign apb_bus.apbRData  = rdata_val;
  assign apb_bus.apbSlvErr = slverr_val;

  always @(posedge clk) begin
    if (apb_bus.apbEnable && !apb_bus.apbReady) acc_cnt <= acc_cnt + 1;
    else                                        acc_cnt <= 0;
  end

  typedef struct {
    logic [NT-1:0] sel;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            setup_len;
    int            acc_len;
  } tx_t;

  tx_t           tx_q[$];
  int            unstable = 0;
  int            total = 0;
  int            bad = 0;

  // Transfer monitor: one log entry (and one printed line) per APB transfer.
  initial begin
    int setup_len = 0;
    int acc_len = 0;
    logic prev_en = 1'b0;
    tx_t cur;
    cur = '{sel: '0, wr: 1'b0, addr: '0, wdata: '0, setup_len: 0, acc_len: 0};
    forever begin
      @(negedge clk);
      if (apb_bus.apbSel != '0 && !apb_bus.apbEnable) begin
        setup_len++;
        acc_len   = 0;
        cur.sel   = apb_bus.apbSel;
        cur.wr    = apb_bus.apbWrite;
        cur.addr  = apb_bus.apbAddr;
        cur.wdata = apb_bus.apbWData;
      end
      if (apb_bus.apbEnable) begin
        acc_len++;
        if (apb_bus.apbSel !== cur.sel || apb_bus.apbWrite !== cur.wr ||
            apb_bus.apbAddr !== cur.addr || apb_bus.apbWData !== cur.wdata)
          unstable++;
      end
      if (prev_en && !apb_bus.apbEnable) begin
        cur.setup_len = setup_len;
        cur.acc_len   = acc_len;
        tx_q.push_back(cur);
        $display("apb transfer: sel=%b wr=%b addr=%h wdata=%h setup=%0d access=%0d",
                 cur.sel, cur.wr, cur.addr, cur.wdata, setup_len, acc_len);
        setup_len = 0;
      end
      prev_en = apb_bus.apbEnable;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    hostAddr = a; host_drv = d; host_oe = 1'b1;
    nHostCS = 1'b0; nHostWrite = 1'b0;
    tick(4);
    nHostWrite = 1'b1; nHostCS = 1'b1;
    tick(4);
    host_oe = 1'b0;
    $display("host write: addr=%h data=%h", a, d);
  endtask

  task automatic host_read(input logic [AW-1:0] a, input int hold,
                           output logic [DW-1:0] during, output logic [DW-1:0] after);
    @(negedge clk);
    hostAddr = a; nHostCS = 1'b0; nHostRead = 1'b0;
    tick(hold);
    during = hostData;
    nHostRead = 1'b1; nHostCS = 1'b1;
    tick(4);
    after = hostData;
    $display("host read: addr=%h during=%h after=%h", a, during, after);
  endtask

  task automatic pulse_clear();
    @(negedge clk); errClear = 1'b1;
    @(negedge clk); errClear = 1'b0;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d_during, d_after;
    int waited;
    nReset = 1'b0; nHostCS = 1'b1; nHostRead = 1'b1; nHostWrite = 1'b1;
    hostAddr = '0; host_drv = '0; host_oe = 1'b0; errClear = 1'b0;
    ready_en = 1'b1; wait_states = 0; rdata_val = '0; slverr_val = 1'b0;
    tick(3);
    check_val("rst_sel",    apb_bus.apbSel, 0);
    check_val("rst_enable", apb_bus.apbEnable, 0);
    check_val("rst_write",  apb_bus.apbWrite, 0);
    check_val("rst_addr",   apb_bus.apbAddr, 0);
    check_val("rst_wdata",  apb_bus.apbWData, 0);
    check_val("rst_errovf", errOverflow, 0);
    check_val("rst_errbus", errBus, 0);
    check_val("rst_hostdata", hostData, 0);
    nReset = 1'b1;
    tick(2);

    // 1: single posted write to region 1
    tx_q.delete();
    host_write(32'h0000_0010, 32'hDEAD_BEEF);
    tick(10);
    check_val("t1_count", tx_q.size(), 1);
    if (tx_q.size() >= 1) begin
      check_val("t1_sel",   tx_q[0].sel, 2'b10);
      check_val("t1_wr",    tx_q[0].wr, 1);
      check_val("t1_addr",  tx_q[0].addr, 32'h10);
      check_val("t1_wdata", tx_q[0].wdata, 32'hDEAD_BEEF);
      check_val("t1_setup", tx_q[0].setup_len, 1);
      check_val("t1_access", tx_q[0].acc_len, 1);
    end

    // 2: overflow with a stalled target, then drain in order
    tx_q.delete();
    ready_en = 1'b0;
    for (int i = 0; i < 5; i++) host_write(32'h0000_0020 + 32'(i), 32'hA0 + 32'(i));
    tick(4);
    check_val("t2_overflow", errOverflow, 1);
    check_val("t2_stalled", tx_q.size(), 0);
    ready_en = 1'b1;
    tick(40);
    check_val("t2_count", tx_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (tx_q.size() > i) begin
        check_val($sformatf("t2_wdata%0d", i), tx_q[i].wdata, 32'hA0 + 32'(i));
        check_val($sformatf("t2_addr%0d", i),  tx_q[i].addr, 32'h20 + 32'(i));
      end
    end
    pulse_clear();
    check_val("t2_ovf_cleared", errOverflow, 0);

    // 3: read ordered behind two posted writes
    tx_q.delete();
    wait_states = 6; rdata_val = 32'h1234_5678;
    host_write(32'h0000_0040, 32'h1111_1111);
    host_write(32'h0000_0044, 32'h2222_2222);
    host_read(32'h0001_0000, 30, d_during, d_after);
    tick(4);
    check_val("t3_count", tx_q.size(), 3);
    if (tx_q.size() >= 3) begin
      check_val("t3_first",  tx_q[0].wdata, 32'h1111_1111);
      check_val("t3_second", tx_q[1].wdata, 32'h2222_2222);
      check_val("t3_rd_wr",  tx_q[2].wr, 0);
      check_val("t3_rd_sel", tx_q[2].sel, 2'b01);
    end
    check_val("t3_hostdata",  d_during, 32'h1234_5678);
    check_val("t3_released",  d_after, 0);

    // 4: read with three wait states and a slave error
    tx_q.delete();
    wait_states = 3; rdata_val = 32'hCAFE_F00D; slverr_val = 1'b1;
    host_read(32'h0001_0004, 20, d_during, d_after);
    slverr_val = 1'b0;
    check_val("t4_count", tx_q.size(), 1);
    if (tx_q.size() >= 1) check_val("t4_access", tx_q[0].acc_len, 4);
    check_val("t4_hostdata", d_during, 32'hCAFE_F00D);
    check_val("t4_errbus", errBus, 1);
    pulse_clear();
    check_val("t4_errbus_clr", errBus, 0);

    // unmatched address: ignored for both writes and reads
    tx_q.delete();
    wait_states = 0;
    host_write(32'h0002_0000, 32'h55);
    host_read(32'h0002_0000, 12, d_during, d_after);
    check_val("nomatch_count", tx_q.size(), 0);
    check_val("nomatch_hostdata", d_during, 0);

`ifdef APB_TIMEOUT_EN
    // 5: stuck target on a read
    tx_q.delete();
    ready_en = 1'b0; rdata_val = 32'h0BAD_0BAD;
    host_read(32'h0001_0008, 40, d_during, d_after);
    ready_en = 1'b1;
    check_val("t5_count", tx_q.size(), 1);
    if (tx_q.size() >= 1) check_val("t5_access", tx_q[0].acc_len, 16);
    check_val("t5_hostdata", d_during, 32'hFFFF_FFFF);
    check_val("t5_errbus", errBus, 1);
    pulse_clear();
`endif

    // 6: asynchronous reset in the middle of ACCESS
    ready_en = 1'b0;
    host_write(32'h0000_0030, 32'h77);
    waited = 0;
    while (!apb_bus.apbEnable && waited < 30) begin
      tick(1);
      waited++;
    end
    check_val("t6_in_access", apb_bus.apbEnable, 1);
    #2 nReset = 1'b0;
    #1;
    check_val("t6_sel",    apb_bus.apbSel, 0);
    check_val("t6_enable", apb_bus.apbEnable, 0);
    check_val("t6_write",  apb_bus.apbWrite, 0);
    check_val("t6_addr",   apb_bus.apbAddr, 0);
    check_val("t6_wdata",  apb_bus.apbWData, 0);
    ready_en = 1'b1;
    tick(2);
    nReset = 1'b1;
    tick(1);
    tx_q.delete();
    host_write(32'h0000_0034, 32'h99);
    tick(10);
    check_val("t6_count", tx_q.size(), 1);
    if (tx_q.size() >= 1) begin
      check_val("t6_after_addr",  tx_q[0].addr, 32'h34);
      check_val("t6_after_wdata", tx_q[0].wdata, 32'h99);
    end

    check_val("stable_during_access", unstable, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
